// File: rtl/cipher_session_ctrl.sv
// Job sequencer for the 8-bit keystream generator: optionally seeds it, then XORs one
// keystream bit per cycle into the message (MSB first) and returns the block via valid/ready.
module cipher_session_ctrl #(
    parameter int unsigned MSG_WIDTH = 64,
    parameter int unsigned KEY_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic                 reseed_i,
    input  logic [KEY_WIDTH-1:0] key_i,
    input  logic [MSG_WIDTH-1:0] msg_i,
    output logic                 busy_o,
    output logic [MSG_WIDTH-1:0] result_o,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic                 ks_load_o,
    output logic                 ks_shift_o,
    output logic [KEY_WIDTH-1:0] ks_seed_o,
    input  logic                 ks_bit_i
);

    localparam int unsigned CntW = (MSG_WIDTH > 1) ? $clog2(MSG_WIDTH) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MSG_WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e                state_q;
    logic [MSG_WIDTH-1:0]  msg_q;
    logic [CntW-1:0]       cnt_q;
    logic                  key_loaded_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= StIdle;
            msg_q          <= '0;
            cnt_q          <= '0;
            key_loaded_q   <= 1'b0;
            busy_o         <= 1'b0;
            result_o       <= '0;
            result_valid_o <= 1'b0;
            ks_load_o      <= 1'b0;
            ks_shift_o     <= 1'b0;
            ks_seed_o      <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    ks_load_o  <= 1'b0;
                    ks_shift_o <= 1'b0;
                    if (start_i) begin
                        msg_q      <= msg_i;
                        ks_seed_o  <= key_i;
                        cnt_q      <= CntMax;
                        busy_o     <= 1'b1;
                        ks_shift_o <= 1'b1;
                        // An unseeded generator is always loaded, whatever reseed_i says.
                        if (reseed_i || !key_loaded_q) begin
                            ks_load_o <= 1'b1;
                            state_q   <= StLoad;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StLoad: begin
                    ks_load_o    <= 1'b0;
                    key_loaded_q <= 1'b1;
                    cnt_q        <= CntMax;
                    state_q      <= StRun;
                end
                StRun: begin
                    result_o[cnt_q] <= msg_q[cnt_q] ^ ks_bit_i;
                    if (cnt_q == '0) begin
                        // Stop shifting on the last bit so the next job continues seamlessly.
                        ks_shift_o     <= 1'b0;
                        busy_o         <= 1'b0;
                        result_valid_o <= 1'b1;
                        state_q        <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    if (result_ready_i) begin
                        result_valid_o <= 1'b0;
                        state_q        <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cipher_session_ctrl.sv
// Bench for cipher_session_ctrl: stands in for the keystream generator and checks each job
// against a word-level model of the keystream XOR.
module tb_cipher_session_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic        reseed_i = 1'b0;
    logic [7:0]  key_i = '0;
    logic [63:0] msg_i = '0;
    logic        result_ready_i = 1'b0;
    logic        busy_o, result_valid_o, ks_load_o, ks_shift_o;
    logic [63:0] result_o;
    logic [7:0]  ks_seed_o;
    logic        ks_bit;

    cipher_session_ctrl #(.MSG_WIDTH(64), .KEY_WIDTH(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .start_i       (start_i),
        .reseed_i      (reseed_i),
        .key_i         (key_i),
        .msg_i         (msg_i),
        .busy_o        (busy_o),
        .result_o      (result_o),
        .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i),
        .ks_load_o     (ks_load_o),
        .ks_shift_o    (ks_shift_o),
        .ks_seed_o     (ks_seed_o),
        .ks_bit_i      (ks_bit)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Generator stand-in: load has priority, output is the register MSB.
    logic [7:0] gen = 8'h00;
    always @(posedge clk) begin
        if (ks_load_o) gen <= ks_seed_o;
        else if (ks_shift_o) gen <= lfsr_step(gen);
    end
    assign ks_bit = gen[7];

    int errs = 0;
    int checks = 0;
    int load_cnt = 0;
    int shift_cnt = 0;

    always @(negedge clk) begin
        if (ks_load_o) load_cnt++;
        if (ks_shift_o) shift_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: generator state as seen by the model, and whether it has been seeded.
    logic [7:0] mdl_g = 8'h00;
    bit         mdl_loaded = 1'b0;

    function automatic logic [127:0] kstream128(input logic [7:0] seed);
        logic [7:0]   s;
        logic [127:0] ks;
        s = seed;
        for (int i = 127; i >= 0; i--) begin
            ks[i] = s[7];
            s = lfsr_step(s);
        end
        return ks;
    endfunction

    task automatic do_job(input logic rs, input logic [7:0] k, input logic [63:0] m,
                          input int hold, input bit poke, output logic [63:0] res);
        logic [63:0] expv;
        int          lat;
        bit          ld;
        ld = rs || !mdl_loaded;
        if (ld) begin
            mdl_g = k;
            mdl_loaded = 1'b1;
        end
        for (int i = 63; i >= 0; i--) begin
            expv[i] = m[i] ^ mdl_g[7];
            mdl_g = lfsr_step(mdl_g);
        end

        @(negedge clk);
        start_i = 1'b1; reseed_i = rs; key_i = k; msg_i = m;
        @(posedge clk); #1;
        start_i = 1'b0; load_cnt = 0; shift_cnt = 0;
        check("busy_after_start", 64'(busy_o), 64'd1);
        lat = 0;
        while (!result_valid_o && lat < 200) begin
            start_i = (poke && lat == 10);
            @(posedge clk); #1;
            lat++;
        end
        start_i = 1'b0;
        check("latency", 64'(lat), ld ? 64'd65 : 64'd64);
        check("result", result_o, expv);
        check("load_pulses", 64'(load_cnt), ld ? 64'd1 : 64'd0);
        check("shift_cycles", 64'(shift_cnt), ld ? 64'd65 : 64'd64);
        check("busy_in_done", 64'(busy_o), 64'd0);
        res = result_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 64'(result_valid_o), 64'd1);
            check("hold_result", result_o, expv);
        end
        @(negedge clk);
        result_ready_i = 1'b1;
        start_i = poke;
        @(posedge clk); #1;
        result_ready_i = 1'b0;
        start_i = 1'b0;
        check("valid_drop", 64'(result_valid_o), 64'd0);
        if (poke) begin
            for (int i = 0; i < 5; i++) begin
                @(posedge clk); #1;
                check("no_extra_busy", 64'(busy_o), 64'd0);
                check("no_extra_valid", 64'(result_valid_o), 64'd0);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_valid"}, 64'(result_valid_o), 64'd0);
        check({tag, "_result"}, result_o, 64'd0);
        check({tag, "_load"}, 64'(ks_load_o), 64'd0);
        check({tag, "_shift"}, 64'(ks_shift_o), 64'd0);
        check({tag, "_seed"}, 64'(ks_seed_o), 64'd0);
    endtask

    localparam logic [63:0] Isl = 64'h4953_4C20_5546_4D47;

    initial begin
        logic [63:0]  rf, r1, r2, ra, rb, rx;
        logic [127:0] ks;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Forced load: no reseed requested, but nothing is seeded yet.
        do_job(1'b0, 8'hF0, Isl, 0, 1'b0, rf);

        // Round trip, with the result held for 10 cycles before acceptance.
        do_job(1'b1, 8'hF0, Isl, 10, 1'b0, r1);
        check("forced_eq_reseed", r1, rf);
        checks++;
        assert (r1 !== Isl) else begin
            errs++;
            $error("FAIL cipher_ne_plain: observed=%0h expected=not %0h", r1, Isl);
        end
        do_job(1'b1, 8'hF0, r1, 0, 1'b0, r2);
        check("round_trip", r2, Isl);

        // Continuation across two jobs equals the first 128 keystream bits.
        ks = kstream128(8'hF0);
        do_job(1'b1, 8'hF0, 64'd0, 0, 1'b0, ra);
        do_job(1'b0, 8'hAA, 64'd0, 0, 1'b0, rb);
        check("cont_a", ra, ks[127:64]);
        check("cont_b", rb, ks[63:0]);

        // Starts during RUN and alongside result_ready in DONE are ignored.
        do_job(1'b0, 8'h11, {$urandom, $urandom}, 2, 1'b1, rx);

        for (int n = 0; n < 6; n++) begin
            do_job(1'($urandom_range(0, 1)), 8'($urandom), {$urandom, $urandom}, 1, 1'b0, rx);
        end

        // Reset in the middle of RUN.
        @(negedge clk);
        start_i = 1'b1; reseed_i = 1'b1; key_i = 8'h3C; msg_i = {$urandom, $urandom};
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (35) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midreset");
        mdl_loaded = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("post_reset_valid", 64'(result_valid_o), 64'd0);
        end
        do_job(1'b0, 8'h5A, {$urandom, $urandom}, 0, 1'b0, rx);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
